// File: rtl/dot_seq.sv
// Dot-product sequencer: walks LEN addresses into the x/m memories, multiplies the returned
// Q(WIDTH-FRAC).FRAC pairs, accumulates with saturation and offers the sum on valid/ready.
module dot_seq #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned FRAC   = 20,
  parameter int unsigned LEN    = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_addr,
  input  logic [WIDTH-1:0]  i_x,
  input  logic [WIDTH-1:0]  i_m,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WIDTH-1:0]  o_result,
  output logic              o_sat
);

  localparam int unsigned        PW       = 2 * WIDTH;
  localparam logic [ADDR_W-1:0]  LastAddr = ADDR_W'(LEN - 1);
  localparam logic [WIDTH-1:0]   MaxVal   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   MinVal   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              sat_q, sat_d;
  logic              dv_q;

  logic signed [PW-1:0] x_ext, m_ext, prod_full, prod_shr;
  logic [WIDTH-1:0]     prod_sat;
  logic                 prod_clamp;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     sum_sat;
  logic                 sum_clamp;

  // Arithmetic shift truncates toward -inf; the product fits only if the bits above the
  // result sign all agree with it.
  always_comb begin
    x_ext      = {{WIDTH{i_x[WIDTH-1]}}, i_x};
    m_ext      = {{WIDTH{i_m[WIDTH-1]}}, i_m};
    prod_full  = x_ext * m_ext;
    prod_shr   = prod_full >>> FRAC;
    prod_clamp = (prod_shr[PW-1:WIDTH-1] != {(WIDTH+1){prod_shr[PW-1]}});
    prod_sat   = prod_clamp ? (prod_shr[PW-1] ? MinVal : MaxVal) : prod_shr[WIDTH-1:0];
    sum        = {acc_q[WIDTH-1], acc_q} + {prod_sat[WIDTH-1], prod_sat};
    sum_clamp  = (sum[WIDTH] != sum[WIDTH-1]);
    sum_sat    = sum_clamp ? (sum[WIDTH] ? MinVal : MaxVal) : sum[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    // dv_q marks the cycle the memories return the pair addressed one cycle earlier.
    if (dv_q) begin
      acc_d = sum_sat;
      sat_d = sat_q | prod_clamp | sum_clamp;
    end
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (cnt_q == LastAddr) begin
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      StDrain: state_d = StDone;
      StDone: begin
        if (i_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      dv_q    <= (state_q == StRun);
    end
  end

  assign o_busy   = (state_q != StIdle);
  assign o_rd_en  = (state_q == StRun);
  assign o_addr   = cnt_q;
  assign o_valid  = (state_q == StDone);
  assign o_result = acc_q;
  assign o_sat    = sat_q;

endmodule

// File: tb/tb_dot_seq.sv
// Directed bench for dot_seq: a LEN=4 instance for the main cases and a LEN=1 instance,
// with a scoreboard queue per instance drained by an independent monitor.
module tb_dot_seq;

  localparam int W  = 24;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start, busy, rd_en, valid, ready, sat;
  logic [AW-1:0] addr;
  logic [W-1:0]  x, m, result;
  logic          start1, busy1, rd_en1, valid1, ready1, sat1;
  logic [AW-1:0] addr1;
  logic [W-1:0]  x1, m1, result1;

  dot_seq #(.WIDTH(24), .FRAC(20), .LEN(4), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .i_start(start), .o_busy(busy), .o_rd_en(rd_en), .o_addr(addr),
    .i_x(x), .i_m(m), .o_valid(valid), .i_ready(ready), .o_result(result), .o_sat(sat)
  );

  dot_seq #(.WIDTH(24), .FRAC(20), .LEN(1), .ADDR_W(3)) dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .o_busy(busy1), .o_rd_en(rd_en1),
    .o_addr(addr1), .i_x(x1), .i_m(m1), .o_valid(valid1), .i_ready(ready1),
    .o_result(result1), .o_sat(sat1)
  );

  // Registered-read memory models
  logic [W-1:0] xmem[8];
  logic [W-1:0] mmem[8];
  logic [W-1:0] x1v, m1v;
  always @(posedge clk) begin
    if (rd_en) begin
      x <= xmem[addr];
      m <= mmem[addr];
    end
    if (rd_en1) begin
      x1 <= x1v;
      m1 <= m1v;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [W:0] exp_q[$];
  logic [W:0] exp1_q[$];
  int         addr_log[$];
  logic [W:0] e0, e1;

  always @(negedge clk) begin
    if (rst === 1'b1 && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected result: got %0h, expected none", result);
      end else begin
        e0 = exp_q.pop_front();
        chk("result", {8'd0, result}, {8'd0, e0[W-1:0]});
        chk("sat", {31'd0, sat}, {31'd0, e0[W]});
      end
    end
    if (rd_en) addr_log.push_back(int'(addr));
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && valid1 && ready1) begin
      if (exp1_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected result (len1): got %0h, expected none", result1);
      end else begin
        e1 = exp1_q.pop_front();
        chk("len1 result", {8'd0, result1}, {8'd0, e1[W-1:0]});
        chk("len1 sat", {31'd0, sat1}, {31'd0, e1[W]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4*W-1:0] xs, input logic [4*W-1:0] ms);
    for (int i = 0; i < 8; i++) begin
      xmem[i] = (i < 4) ? xs[i*W +: W] : '0;
      mmem[i] = (i < 4) ? ms[i*W +: W] : '0;
    end
  endtask

  task automatic load_t1();
    load({24'h040000, 24'hF80000, 24'h200000, 24'h100000},
         {24'h400000, 24'h200000, 24'h080000, 24'h080000});
  endtask

  task automatic pulse(input bit sel);
    if (sel) start1 = 1'b1; else start = 1'b1;
    tick();
    start1 = 1'b0;
    start  = 1'b0;
  endtask

  // n counts cycles from the start-sampling edge; returns when o_valid is seen.
  task automatic wait_valid(input bit sel, output int n);
    n = 1;
    while (!(sel ? valid1 : valid) && n < 40) begin
      tick();
      n++;
    end
    if (!(sel ? valid1 : valid)) begin
      n_vec++;
      n_err++;
      $display("FAIL valid timeout: got no valid after %0d cycles, expected valid", n);
    end
  endtask

  task automatic chk_addrs(input string name);
    chk({name, " addr count"}, addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) chk({name, " addr"}, addr_log[i], i);
  endtask

  int n;

  initial begin
    rst = 1'b0; start = 1'b0; start1 = 1'b0; ready = 1'b1; ready1 = 1'b1;
    x = '0; m = '0; x1 = '0; m1 = '0; x1v = '0; m1v = '0;
    load_t1();
    repeat (3) tick();
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset rd_en", {31'd0, rd_en}, 0);
    chk("reset valid", {31'd0, valid}, 0);
    chk("reset addr", {29'd0, addr}, 0);
    chk("reset result", {8'd0, result}, 0);
    chk("reset sat", {31'd0, sat}, 0);
    rst = 1'b1;
    tick();

    // Basic dot product and latency
    load_t1();
    addr_log.delete();
    exp_q.push_back({1'b0, 24'h180000});
    pulse(0);
    wait_valid(0, n);
    chk("t1 latency", n, 6);
    chk_addrs("t1");
    repeat (2) tick();
    chk("t1 busy after", {31'd0, busy}, 0);

    // Saturation both directions
    load({4{24'h700000}}, {4{24'h700000}});
    exp_q.push_back({1'b1, 24'h7FFFFF});
    pulse(0);
    wait_valid(0, n);
    repeat (2) tick();
    load({4{24'h800000}}, {4{24'h700000}});
    exp_q.push_back({1'b1, 24'h800000});
    pulse(0);
    wait_valid(0, n);
    repeat (2) tick();

    // Backpressure
    load_t1();
    ready = 1'b0;
    exp_q.push_back({1'b0, 24'h180000});
    pulse(0);
    wait_valid(0, n);
    for (int i = 0; i < 10; i++) begin
      chk("bp valid", {31'd0, valid}, 1);
      chk("bp result", {8'd0, result}, 32'h180000);
      tick();
    end
    ready = 1'b1;
    tick();
    chk("bp valid after", {31'd0, valid}, 0);
    chk("bp busy after", {31'd0, busy}, 0);

    // Starts in RUN and DONE are ignored
    ready = 1'b0;
    addr_log.delete();
    exp_q.push_back({1'b0, 24'h180000});
    pulse(0);
    tick();
    pulse(0);
    wait_valid(0, n);
    pulse(0);
    ready = 1'b1;
    repeat (4) tick();
    chk("ign busy", {31'd0, busy}, 0);
    chk_addrs("ign");

    // Reset in the middle of RUN
    pulse(0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("mid-rst busy", {31'd0, busy}, 0);
    chk("mid-rst rd_en", {31'd0, rd_en}, 0);
    chk("mid-rst addr", {29'd0, addr}, 0);
    chk("mid-rst valid", {31'd0, valid}, 0);
    chk("mid-rst result", {8'd0, result}, 0);
    chk("mid-rst sat", {31'd0, sat}, 0);
    rst = 1'b1;
    tick();
    exp_q.push_back({1'b0, 24'h180000});
    pulse(0);
    wait_valid(0, n);
    chk("post-rst latency", n, 6);
    repeat (2) tick();

    // LEN=1 instance
    x1v = 24'hF00000;
    m1v = 24'h0C0000;
    exp1_q.push_back({1'b0, 24'hF40000});
    pulse(1);
    wait_valid(1, n);
    chk("len1 latency", n, 3);
    repeat (3) tick();

    chk("pending results", exp_q.size(), 0);
    chk("pending len1 results", exp1_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
